// File: rtl/two_way_cache.sv
// two_way_cache: 2-way set-associative, write-through, no-write-allocate cache with per-set LRU bit.
// Define CACHE_STATS_EN to add hit_count/miss_count read-statistics outputs.

module two_way_cache_way #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_WIDTH  = 2,
  parameter int TAG_WIDTH  = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SET_WIDTH-1:0]  set,
  input  logic                  fill,
  input  logic                  wr,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int SETS = 1 << SET_WIDTH;

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  always_ff @(posedge clk) begin
    if (rst)       valid_q      <= '0;
    else if (fill) valid_q[set] <= 1'b1;
  end

  // tag/data arrays carry no reset; enables arrive already gated by rst
  always_ff @(posedge clk) begin
    if (fill)       tag_q[set]  <= tag_in;
    if (fill || wr) data_q[set] <= data_in;
  end

  assign valid = valid_q[set];
  assign tag   = tag_q[set];
  assign data  = data_q[set];
endmodule

module two_way_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  ready,
  output logic                  hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int TAG_WIDTH = DATA_WIDTH - SET_WIDTH - 2;
  localparam int SETS      = 1 << SET_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state, next_state;

  logic [SET_WIDTH-1:0]       set;
  logic [TAG_WIDTH-1:0]       tag;
  logic [1:0]                 way_valid;
  logic [1:0][TAG_WIDTH-1:0]  way_tag;
  logic [1:0][DATA_WIDTH-1:0] way_data;
  logic [1:0]                 hit_vec, fill_en, wr_en;
  logic                       hit_way, victim;
  logic [DATA_WIDTH-1:0]      way_wdata;
  logic [SETS-1:0]            lru;
  logic                       lru_upd, lru_new;
  logic                       cnt_hit, cnt_fill;
  logic                       unused_addr_lsb;

  assign set             = address[SET_WIDTH+1:2];
  assign tag             = address[DATA_WIDTH-1:SET_WIDTH+2];
  assign unused_addr_lsb = &{1'b0, address[1:0]};
  assign way_wdata       = (state == FILL) ? mem_rdata : datain;

  for (genvar w = 0; w < 2; w++) begin : g_way
    two_way_cache_way #(
      .DATA_WIDTH(DATA_WIDTH), .SET_WIDTH(SET_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) u_way (
      .clk(clk), .rst(rst), .set(set),
      .fill(fill_en[w]), .wr(wr_en[w]),
      .tag_in(tag), .data_in(way_wdata),
      .valid(way_valid[w]), .tag(way_tag[w]), .data(way_data[w])
    );
    assign hit_vec[w] = !rst && way_valid[w] && (way_tag[w] == tag);
  end

  // at most one way can match, so way1's match bit doubles as the way index
  assign hit_way = hit_vec[1];
  assign hit     = |hit_vec;
  assign victim  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[set]);

  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = mem_req ? address : '0;
  assign mem_wdata = mem_req ? datain  : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst)          lru      <= '0;
    else if (lru_upd) lru[set] <= lru_new;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    dataout    = '0;
    fill_en    = '0;
    wr_en      = '0;
    lru_upd    = 1'b0;
    lru_new    = 1'b0;
    cnt_hit    = 1'b0;
    cnt_fill   = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        if (we) next_state = WRITE;
        else if (hit) begin
          ready   = 1'b1;
          dataout = way_data[hit_way];
          lru_upd = 1'b1;
          lru_new = ~hit_way;
          cnt_hit = 1'b1;
        end else next_state = FILL;
      end
      FILL: if (mem_ack) begin
        ready           = 1'b1;
        dataout         = mem_rdata;
        fill_en[victim] = 1'b1;
        lru_upd         = 1'b1;
        lru_new         = ~victim;
        cnt_fill        = 1'b1;
        next_state      = IDLE;
      end
      WRITE: if (mem_ack) begin
        ready = 1'b1;
        if (hit) begin
          wr_en[hit_way] = 1'b1;
          lru_upd        = 1'b1;
          lru_new        = ~hit_way;
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // a reset edge abandons any transaction without touching the arrays
    if (rst) begin
      ready    = 1'b0;
      dataout  = '0;
      fill_en  = '0;
      wr_en    = '0;
      lru_upd  = 1'b0;
      cnt_hit  = 1'b0;
      cnt_fill = 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (cnt_hit)  hit_count  <= hit_count + 32'd1;
      if (cnt_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_two_way_cache.sv
// Bench for two_way_cache: directed scenarios then random traffic checked against
// a recency-list cache model and a word-addressed memory model.
module tb_two_way_cache;
  localparam int DW = 32, SW = 2, NSETS = 4;

  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, we = 1'b0, mem_ack = 1'b0;
  logic [31:0] address = '0, datain = '0, mem_rdata = '0;
  logic [31:0] dataout, mem_addr, mem_wdata;
  logic ready, hit, mem_req, mem_we;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0, errors = 0;

  two_way_cache #(.DATA_WIDTH(DW), .SET_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .we(we), .address(address),
    .datain(datain), .dataout(dataout), .ready(ready), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // per set: entries ordered most-recent first, m_cnt of them live
  logic [31:0] m_tag [NSETS][2];
  logic [31:0] m_dat [NSETS][2];
  int          m_cnt [NSETS];
  int          m_hits = 0, m_miss = 0;
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] got_data;
  logic        got_hit;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic int m_find(input int s, input logic [31:0] t);
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) return i;
    return -1;
  endfunction

  task automatic m_touch(input int s, input int i);
    logic [31:0] t, d;
    if (i == 1) begin
      t = m_tag[s][0]; d = m_dat[s][0];
      m_tag[s][0] = m_tag[s][1]; m_dat[s][0] = m_dat[s][1];
      m_tag[s][1] = t; m_dat[s][1] = d;
    end
  endtask

  task automatic m_insert(input int s, input logic [31:0] t, input logic [31:0] d);
    m_tag[s][1] = m_tag[s][0]; m_dat[s][1] = m_dat[s][0];
    m_tag[s][0] = t; m_dat[s][0] = d;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic m_clear();
    for (int i = 0; i < NSETS; i++) m_cnt[i] = 0;
    m_hits = 0; m_miss = 0;
  endtask

  // one CPU transaction with a memory responder acking after lat request cycles
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat);
    int s, idx, cyc, reqc;
    logic done;
    s = int'(a[3:2]);
    idx = m_find(s, {4'b0, a[31:4]});
    @(negedge clk);
    req_valid = 1'b1; we = w; address = a; datain = d; mem_ack = 1'b0;
    cyc = 0; reqc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      #1;
      if (mem_req) begin
        reqc++;
        mem_ack   = (reqc >= lat);
        mem_rdata = mem_ack ? mem_rd(a) : $urandom;
      end
      #1;
      if (cyc == 0) begin
        got_hit = hit;
        check("hit", hit, idx >= 0);
      end
      if (ready) begin
        done = 1'b1;
        got_data = dataout;
        check("latency", cyc, (!w && idx >= 0) ? 0 : lat);
        if (!w) check("rdata", dataout, (idx >= 0) ? m_dat[s][idx] : mem_rd(a));
        else    check("wr_dout", dataout, 0);
        if (cyc > 0) begin
          check("mem_we", mem_we, w);
          check("mem_addr", mem_addr, a);
          if (w) check("mem_wdata", mem_wdata, d);
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("timeout", done, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_ack = 1'b0;
    if (w) begin
      mem_m[a] = d;
      if (idx >= 0) begin m_dat[s][idx] = d; m_touch(s, idx); end
    end else if (idx >= 0) begin
      m_touch(s, idx); m_hits++;
    end else begin
      m_insert(s, {4'b0, a[31:4]}, mem_rd(a)); m_miss++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_hit", hit, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_mem_req", mem_req, 0);
    check("post_rst_ready", ready, 0);
    m_clear();
  endtask

  initial begin
    m_clear();
    do_reset();
`ifdef CACHE_STATS_EN
    check("stats_rst_hit", hit_count, 0);
    check("stats_rst_miss", miss_count, 0);
`endif

    // basic fill then hit
    mem_m[32'h10] = 32'hDEAD_BEEF;
    access(1'b0, 32'h10, '0, 3);
    check("r30_miss", got_hit, 0);
    check("r30_fill_data", got_data, 32'hDEAD_BEEF);
    access(1'b0, 32'h10, '0, 3);
    check("r30_hit", got_hit, 1);
    check("r30_hit_data", got_data, 32'hDEAD_BEEF);
`ifdef CACHE_STATS_EN
    check("stats_hit", hit_count, 1);
    check("stats_miss", miss_count, 1);
`endif

    // LRU eviction in set 0
    do_reset();
    access(1'b0, 32'h00, '0, 2);
    access(1'b0, 32'h10, '0, 2);
    access(1'b0, 32'h20, '0, 2);
    access(1'b0, 32'h10, '0, 1);
    check("r31_hit_10", got_hit, 1);
    access(1'b0, 32'h00, '0, 1);
    check("r31_miss_00", got_hit, 0);

    // a hit refreshes recency
    do_reset();
    access(1'b0, 32'h00, '0, 2);
    access(1'b0, 32'h10, '0, 2);
    access(1'b0, 32'h00, '0, 2);
    check("r32_hit_00", got_hit, 1);
    access(1'b0, 32'h20, '0, 2);
    access(1'b0, 32'h00, '0, 2);
    check("r32_keep_00", got_hit, 1);
    access(1'b0, 32'h10, '0, 2);
    check("r32_evict_10", got_hit, 0);

    // write-through hit and no-allocate miss
    do_reset();
    access(1'b0, 32'h00, '0, 2);
    access(1'b1, 32'h00, 32'h1234_5678, 2);
    access(1'b0, 32'h00, '0, 2);
    check("r33_hit", got_hit, 1);
    check("r33_data", got_data, 32'h1234_5678);
    access(1'b1, 32'h40, 32'h0000_A5A5, 3);
    access(1'b0, 32'h40, '0, 2);
    check("r33_no_alloc", got_hit, 0);
    check("r33_mem_data", got_data, 32'h0000_A5A5);

    // reset on the ack cycle of a fill
    @(negedge clk);
    req_valid = 1'b1; we = 1'b0; address = 32'h70;
    @(negedge clk);
    #1;
    check("r34_fill_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; rst = 1'b1;
    @(negedge clk);
    #1;
    check("r34_req_drop", mem_req, 0);
    check("r34_ready", ready, 0);
    rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
    m_clear();
    access(1'b0, 32'h70, '0, 2);
    check("r34_miss", got_hit, 0);

    // random traffic over a small address pool
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      access($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(1, 4));
    end
`ifdef CACHE_STATS_EN
    check("stats_rand_hit", hit_count, m_hits);
    check("stats_rand_miss", miss_count, m_miss);
    do_reset();
    check("stats_end_hit", hit_count, 0);
    check("stats_end_miss", miss_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/two_way_cache.md
TWO_WAY_CACHE -- requirements
Module: two_way_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address and data width in bits.
REQ-002 SHALL have parameter SET_WIDTH, default 2, giving 2^SET_WIDTH sets of 2 ways; TAG_WIDTH = DATA_WIDTH-SET_WIDTH-2 (derived, not a port parameter).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  CPU request present; held with addr/we/wdata stable until ready.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 address  input  DATA_WIDTH  word address; set = address[SET_WIDTH+1:2], tag = upper TAG_WIDTH bits.
REQ-008 datain  input  DATA_WIDTH  write data.
REQ-009 dataout  output  DATA_WIDTH  read data, valid when ready && !we.
REQ-010 ready  output  1  request completes this cycle.
REQ-011 hit  output  1  combinational tag match in either way for current address.
REQ-012 mem_req, mem_we  output  1 each  memory request / write strobe.
REQ-013 mem_addr, mem_wdata  output  DATA_WIDTH  driven from address/datain while mem_req.
REQ-014 mem_rdata  input  DATA_WIDTH; mem_ack  input  1  memory completion, any latency >= 1 cycle.

Function
REQ-015 Storage per set: 2 ways of {valid, tag, data}, plus 1 LRU bit (index of least recently used way).
REQ-016 FSM states IDLE, FILL, WRITE; mem_req = (state != IDLE); mem_we = (state == WRITE).
REQ-017 IDLE, req_valid, !we, hit: ready=1 same cycle, dataout = hitting way's data, LRU := other way; stay IDLE.
REQ-018 IDLE, req_valid, !we, miss: ready=0, go FILL.
REQ-019 IDLE, req_valid, we: ready=0, go WRITE (write-through, every write).
REQ-020 FILL: hold until mem_ack; on ack cycle ready=1, dataout = mem_rdata (forwarded); at edge victim way gets {1, tag, mem_rdata}, LRU := other way, go IDLE.
REQ-021 Victim: way0 if invalid, else way1 if invalid, else way[LRU].
REQ-022 WRITE: hold until mem_ack; on ack cycle ready=1; at edge if hit, hitting way data := datain and LRU := other way; if miss, cache unchanged (no write-allocate); go IDLE.
REQ-023 ready=0 and dataout=0 in all cases not covered above; req_valid=0 in IDLE causes no state change.
REQ-024 Both ways never hold the same valid tag in one set.

Reset
REQ-025 On rst at clock edge: all valid and LRU bits 0, state IDLE; data/tag arrays not reset.
REQ-026 Reset mid-FILL/WRITE abandons the transaction; mem_req=0 from the cycle after the reset edge; no cache update occurs on that edge even if mem_ack is high.
REQ-027 While in reset cycle outputs follow IDLE rules with all entries invalid: ready=0, hit=0.

Configuration
REQ-028 Macro CACHE_STATS_EN: when defined, SHALL add outputs hit_count and miss_count (32 bits each, reset 0) counting completed read hits (REQ-017) and read fills (REQ-020), wrapping at 2^32; writes not counted.
REQ-029 Without CACHE_STATS_EN the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 After reset, read 0x0000_0010, memory returns 0xDEAD_BEEF after 3 cycles -> ready on ack cycle with dataout 0xDEAD_BEEF; repeat read -> ready same cycle, hit=1, same data.
REQ-031 Reads 0x00, 0x10, 0x20 (all set 0, SET_WIDTH=2): fills way0, way1, then evicts way0 (LRU); re-read 0x10 hits, 0x00 misses.
REQ-032 Read 0x00 (hit installed), then read 0x10, read 0x00, read 0x20 -> 0x20 evicts 0x10 (LRU tracks hit on 0x00).
REQ-033 Write 0x1234_5678 to cached 0x00 -> mem_req/mem_we high until ack, then read 0x00 hits returning 0x1234_5678; write to uncached 0x40 -> subsequent read 0x40 misses.
REQ-034 Assert rst during FILL with mem_ack high -> mem_req low next cycle, read of same address misses.
REQ-035 With CACHE_STATS_EN, REQ-030 sequence -> hit_count=1, miss_count=1; after rst both 0.
